// File: rtl/mem2axi_bridge.sv
// Single-outstanding bridge from a req/gnt memory port to single-beat AXI4 INCR transfers.
// Define MEM2AXI_BRIDGE_RESP_CUT_EN to register the memory-side response by one cycle.
module mem2axi_bridge #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AxiId     = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output logic                   busy_o,

  output logic                   axi_aw_valid_o,
  input  logic                   axi_aw_ready_i,
  output logic [AddrWidth-1:0]   axi_aw_addr_o,
  output logic [IdWidth-1:0]     axi_aw_id_o,
  output logic [7:0]             axi_aw_len_o,
  output logic [2:0]             axi_aw_size_o,
  output logic [1:0]             axi_aw_burst_o,

  output logic                   axi_w_valid_o,
  input  logic                   axi_w_ready_i,
  output logic [DataWidth-1:0]   axi_w_data_o,
  output logic [DataWidth/8-1:0] axi_w_strb_o,
  output logic                   axi_w_last_o,

  input  logic                   axi_b_valid_i,
  output logic                   axi_b_ready_o,
  input  logic [1:0]             axi_b_resp_i,

  output logic                   axi_ar_valid_o,
  input  logic                   axi_ar_ready_i,
  output logic [AddrWidth-1:0]   axi_ar_addr_o,
  output logic [IdWidth-1:0]     axi_ar_id_o,
  output logic [7:0]             axi_ar_len_o,
  output logic [2:0]             axi_ar_size_o,
  output logic [1:0]             axi_ar_burst_o,

  input  logic                   axi_r_valid_i,
  output logic                   axi_r_ready_o,
  input  logic [DataWidth-1:0]   axi_r_data_i,
  input  logic [1:0]             axi_r_resp_i,
  input  logic                   axi_r_last_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SizeLog   = $clog2(StrbWidth);
  localparam logic [AddrWidth-1:0] AddrMask = ~AddrWidth'(StrbWidth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRespOut
  } state_e;

`ifdef MEM2AXI_BRIDGE_RESP_CUT_EN
  localparam state_e StAfterResp = StRespOut;
`else
  localparam state_e StAfterResp = StIdle;
`endif

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   strb_q;
  logic                   aw_pend_q, w_pend_q;

  logic                   resp_valid;
  logic [DataWidth-1:0]   resp_data;
  logic                   resp_err;

  // Only the error bit of the response matters; single-beat reads make r_last redundant.
  logic unused_resp;
  assign unused_resp = ^{axi_b_resp_i[0], axi_r_resp_i[0], axi_r_last_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else if (mem_req_i && mem_gnt_o) begin
      addr_q    <= mem_addr_i & AddrMask;
      wdata_q   <= mem_wdata_i;
      strb_q    <= mem_strb_i;
      aw_pend_q <= mem_we_i;
      w_pend_q  <= mem_we_i;
    end else if (state_q == StWrReq) begin
      if (axi_aw_ready_i) aw_pend_q <= 1'b0;
      if (axi_w_ready_i)  w_pend_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (mem_req_i) state_d = mem_we_i ? StWrReq : StRdReq;
      end
      StWrReq: begin
        // AW and W retire independently; leave once neither is still pending.
        if ((!aw_pend_q || axi_aw_ready_i) && (!w_pend_q || axi_w_ready_i)) state_d = StWrResp;
      end
      StWrResp: begin
        if (axi_b_valid_i) state_d = StAfterResp;
      end
      StRdReq: begin
        if (axi_ar_ready_i) state_d = StRdResp;
      end
      StRdResp: begin
        if (axi_r_valid_i) state_d = StAfterResp;
      end
      StRespOut: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_gnt_o      = 1'b0;
    busy_o         = (state_q != StIdle);
    axi_aw_valid_o = 1'b0;
    axi_w_valid_o  = 1'b0;
    axi_b_ready_o  = 1'b0;
    axi_ar_valid_o = 1'b0;
    axi_r_ready_o  = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    resp_err       = 1'b0;
    case (state_q)
      StIdle:  mem_gnt_o = mem_req_i;
      StWrReq: begin
        axi_aw_valid_o = aw_pend_q;
        axi_w_valid_o  = w_pend_q;
      end
      StWrResp: begin
        axi_b_ready_o = 1'b1;
        resp_valid    = axi_b_valid_i;
        resp_err      = axi_b_valid_i & axi_b_resp_i[1];
      end
      StRdReq:  axi_ar_valid_o = 1'b1;
      StRdResp: begin
        axi_r_ready_o = 1'b1;
        resp_valid    = axi_r_valid_i;
        resp_data     = axi_r_valid_i ? axi_r_data_i : '0;
        resp_err      = axi_r_valid_i & axi_r_resp_i[1];
      end
      default: ;
    endcase
  end

`ifdef MEM2AXI_BRIDGE_RESP_CUT_EN
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= resp_valid;
      if (resp_valid) begin
        rdata_q <= resp_data;
        err_q   <= resp_err;
      end
    end
  end

  assign mem_rvalid_o = rvalid_q;
  assign mem_rdata_o  = rdata_q;
  assign mem_err_o    = err_q;
`else
  assign mem_rvalid_o = resp_valid;
  assign mem_rdata_o  = resp_data;
  assign mem_err_o    = resp_err;
`endif

  assign axi_aw_addr_o  = addr_q;
  assign axi_aw_id_o    = IdWidth'(AxiId);
  assign axi_aw_len_o   = 8'd0;
  assign axi_aw_size_o  = 3'(SizeLog);
  assign axi_aw_burst_o = 2'b01;

  assign axi_w_data_o   = wdata_q;
  assign axi_w_strb_o   = strb_q;
  assign axi_w_last_o   = 1'b1;

  assign axi_ar_addr_o  = addr_q;
  assign axi_ar_id_o    = IdWidth'(AxiId);
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_size_o  = 3'(SizeLog);
  assign axi_ar_burst_o = 2'b01;

endmodule

// File: tb/tb_mem2axi_bridge.sv
// Directed and randomised bench for mem2axi_bridge; a transaction queue models the
// expected AXI traffic, handshake timing and memory-side responses.
module tb_mem2axi_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;
`ifdef MEM2AXI_BRIDGE_RESP_CUT_EN
  localparam int unsigned RespLat = 1;
`else
  localparam int unsigned RespLat = 0;
`endif

  logic          clk_i, rst_ni;
  logic          mem_req_i, mem_gnt_o, mem_we_i, mem_rvalid_o, mem_err_o, busy_o;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i, mem_rdata_o;
  logic [SW-1:0] mem_strb_i;
  logic          axi_aw_valid_o, axi_aw_ready_i;
  logic [AW-1:0] axi_aw_addr_o, axi_ar_addr_o;
  logic [IW-1:0] axi_aw_id_o, axi_ar_id_o;
  logic [7:0]    axi_aw_len_o, axi_ar_len_o;
  logic [2:0]    axi_aw_size_o, axi_ar_size_o;
  logic [1:0]    axi_aw_burst_o, axi_ar_burst_o;
  logic          axi_w_valid_o, axi_w_ready_i, axi_w_last_o;
  logic [DW-1:0] axi_w_data_o, axi_r_data_i;
  logic [SW-1:0] axi_w_strb_o;
  logic          axi_b_valid_i, axi_b_ready_o;
  logic [1:0]    axi_b_resp_i, axi_r_resp_i;
  logic          axi_ar_valid_o, axi_ar_ready_i;
  logic          axi_r_valid_i, axi_r_ready_o, axi_r_last_i;

  mem2axi_bridge #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .AxiId(0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
    .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
    .busy_o(busy_o),
    .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
    .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_id_o(axi_aw_id_o), .axi_aw_len_o(axi_aw_len_o),
    .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i), .axi_w_data_o(axi_w_data_o),
    .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
    .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o), .axi_b_resp_i(axi_b_resp_i),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_id_o(axi_ar_id_o), .axi_ar_len_o(axi_ar_len_o),
    .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o), .axi_r_data_i(axi_r_data_i),
    .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    int unsigned   aw_dly, w_dly, ar_dly, rsp_dly;
  } txn_t;

  txn_t          txn_q[$];
  int unsigned   nk_aw, nk_w, nk_ar, nk_rsp;
  logic [DW-1:0] nk_rdata;
  logic [1:0]    nk_resp;
  logic          stray;
  int unsigned   n_checks, n_errors, cyc, dut_gcyc;
  logic          m_aw_done, m_w_done, m_ar_done, m_resp_done;
  int unsigned   m_aw_cnt, m_w_cnt, m_ar_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: expected handshake phases and responses, sampled mid-cycle.
  always @(negedge clk_i) begin : monitor
    txn_t        e;
    txn_t        n;
    logic        have, exp_gnt, exp_awv, exp_wv, exp_arv, exp_br, exp_rr, exp_hs, exp_rv;
    int unsigned mx;
    cyc++;
    if (!rst_ni) begin
      txn_q.delete();
      {m_aw_done, m_w_done, m_ar_done, m_resp_done} = '0;
      m_aw_cnt = 0; m_w_cnt = 0; m_ar_cnt = 0;
    end else begin
      have = (txn_q.size() != 0);
      e = '{default: 0};
      if (have) e = txn_q[0];
      exp_gnt = mem_req_i && !have;
      exp_awv = have && e.we && !m_aw_done && !m_resp_done;
      exp_wv  = have && e.we && !m_w_done && !m_resp_done;
      exp_arv = have && !e.we && !m_ar_done && !m_resp_done;
      exp_br  = have && e.we && m_aw_done && m_w_done && !m_resp_done;
      exp_rr  = have && !e.we && m_ar_done && !m_resp_done;
      check("gnt", mem_gnt_o, exp_gnt);
      check("busy", busy_o, have);
      check("aw_valid", axi_aw_valid_o, exp_awv);
      check("w_valid", axi_w_valid_o, exp_wv);
      check("ar_valid", axi_ar_valid_o, exp_arv);
      check("b_ready", axi_b_ready_o, exp_br);
      check("r_ready", axi_r_ready_o, exp_rr);
      if (mem_gnt_o && mem_req_i) dut_gcyc = cyc;
      if (axi_aw_valid_o) m_aw_cnt++;
      if (axi_w_valid_o)  m_w_cnt++;
      if (axi_ar_valid_o) m_ar_cnt++;
      if (exp_awv) begin
        check("aw_addr", axi_aw_addr_o, e.addr);
        if (axi_aw_ready_i) begin
          check("aw_hold", m_aw_cnt, e.aw_dly + 1);
          check("aw_fields", {axi_aw_id_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o},
                {IW'(0), 8'd0, 3'($clog2(SW)), 2'b01});
          m_aw_done = 1'b1;
        end
      end
      if (exp_wv) begin
        check("w_data", axi_w_data_o, e.wdata);
        check("w_strb_last", {axi_w_strb_o, axi_w_last_o}, {e.strb, 1'b1});
        if (axi_w_ready_i) begin
          check("w_hold", m_w_cnt, e.w_dly + 1);
          m_w_done = 1'b1;
        end
      end
      if (exp_arv) begin
        check("ar_addr", axi_ar_addr_o, e.addr);
        if (axi_ar_ready_i) begin
          check("ar_hold", m_ar_cnt, e.ar_dly + 1);
          check("ar_fields", {axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o},
                {IW'(0), 8'd0, 3'($clog2(SW)), 2'b01});
          m_ar_done = 1'b1;
        end
      end
      exp_hs = (exp_br && axi_b_valid_i) || (exp_rr && axi_r_valid_i);
      exp_rv = (RespLat == 0) ? exp_hs : m_resp_done;
      check("rvalid", mem_rvalid_o, exp_rv);
      if (exp_rv) begin
        check("rdata", mem_rdata_o, e.we ? '0 : e.rdata);
        check("err", mem_err_o, e.resp[1]);
        mx = e.we ? ((e.aw_dly > e.w_dly) ? e.aw_dly : e.w_dly) : e.ar_dly;
        check("latency", cyc - dut_gcyc, 2 + mx + e.rsp_dly + RespLat);
        void'(txn_q.pop_front());
        {m_aw_done, m_w_done, m_ar_done, m_resp_done} = '0;
        m_aw_cnt = 0; m_w_cnt = 0; m_ar_cnt = 0;
      end else if (exp_hs) begin
        m_resp_done = 1'b1;
      end
      if (exp_gnt) begin
        n.we = mem_we_i; n.addr = mem_addr_i & ~AW'(SW - 1);
        n.wdata = mem_wdata_i; n.strb = mem_strb_i;
        n.rdata = nk_rdata; n.resp = nk_resp;
        n.aw_dly = nk_aw; n.w_dly = nk_w; n.ar_dly = nk_ar; n.rsp_dly = nk_rsp;
        txn_q.push_back(n);
      end
    end
  end

  // AXI responder: each ready rises after its channel's valid has waited the chosen delay.
  initial begin : responder
    int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    txn_t        e;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    {aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs, b_hs, r_hs} = '0;
    {axi_aw_ready_i, axi_w_ready_i, axi_ar_ready_i, axi_b_valid_i, axi_r_valid_i} = '0;
    axi_b_resp_i = 2'b00; axi_r_resp_i = 2'b00; axi_r_data_i = '0; axi_r_last_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        {aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs, b_hs, r_hs} = '0;
        {axi_aw_ready_i, axi_w_ready_i, axi_ar_ready_i, axi_b_valid_i, axi_r_valid_i} = '0;
      end else begin
        if (aw_hs) aw_done = 1'b1;
        if (w_hs)  w_done  = 1'b1;
        if (ar_hs) ar_done = 1'b1;
        if (b_hs) begin aw_done = 1'b0; w_done = 1'b0; b_cnt = 0; end
        if (r_hs) begin ar_done = 1'b0; r_cnt = 0; end
        e = '{default: 0};
        if (txn_q.size() != 0) e = txn_q[0];
        axi_aw_ready_i = axi_aw_valid_o && (aw_cnt >= e.aw_dly);
        axi_w_ready_i  = axi_w_valid_o && (w_cnt >= e.w_dly);
        axi_ar_ready_i = axi_ar_valid_o && (ar_cnt >= e.ar_dly);
        aw_hs = axi_aw_ready_i; w_hs = axi_w_ready_i; ar_hs = axi_ar_ready_i;
        if (axi_aw_valid_o) aw_cnt = aw_hs ? 0 : aw_cnt + 1;
        if (axi_w_valid_o)  w_cnt  = w_hs  ? 0 : w_cnt + 1;
        if (axi_ar_valid_o) ar_cnt = ar_hs ? 0 : ar_cnt + 1;
        if (aw_done && w_done) begin
          axi_b_valid_i = (b_cnt >= e.rsp_dly);
          axi_b_resp_i  = e.resp;
          if (!axi_b_valid_i) b_cnt++;
        end else begin
          axi_b_valid_i = stray && (txn_q.size() == 0);
          axi_b_resp_i  = 2'b10;
        end
        if (ar_done) begin
          axi_r_valid_i = (r_cnt >= e.rsp_dly);
          axi_r_data_i  = e.rdata;
          axi_r_resp_i  = e.resp;
          if (!axi_r_valid_i) r_cnt++;
        end else begin
          axi_r_valid_i = stray && (txn_q.size() == 0);
          axi_r_data_i  = {$urandom, $urandom};
          axi_r_resp_i  = 2'b10;
        end
        axi_r_last_i = 1'b1;
        b_hs = axi_b_valid_i && axi_b_ready_o;
        r_hs = axi_r_valid_i && axi_r_ready_o;
      end
    end
  end

  // Leaves mem_req_i high after the grant so the caller can chain requests back to back.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] strb, input int unsigned awd, input int unsigned wdd,
                        input int unsigned ard, input int unsigned rspd,
                        input logic [DW-1:0] rd, input logic [1:0] resp);
    logic got;
    @(posedge clk_i); #1;
    nk_aw = awd; nk_w = wdd; nk_ar = ard; nk_rsp = rspd; nk_rdata = rd; nk_resp = resp;
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_strb_i = strb;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i); #1;
      if (mem_gnt_o) got = 1'b1;
    end
    check("gnt_timeout", got, 1'b1);
  endtask

  task automatic idle(input int unsigned n);
    @(posedge clk_i); #1;
    mem_req_i = 1'b0;
    repeat (n) @(posedge clk_i);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && txn_q.size() != 0; i++) @(posedge clk_i);
    check("drain", txn_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valids"}, {axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o, axi_b_ready_o,
          axi_r_ready_o}, 5'b0);
    check({tag, "_resp"}, {mem_rvalid_o, mem_err_o, busy_o, mem_gnt_o}, 4'b0);
    check({tag, "_rdata"}, mem_rdata_o, '0);
    check({tag, "_payload"}, {axi_aw_addr_o, axi_w_strb_o}, '0);
  endtask

  initial begin : main
    logic          we;
    logic [AW-1:0] a;
    n_checks = 0; n_errors = 0; cyc = 0; dut_gcyc = 0; stray = 1'b0;
    nk_aw = 0; nk_w = 0; nk_ar = 0; nk_rsp = 0; nk_rdata = '0; nk_resp = 2'b00;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_strb_i = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;

    // Minimum-latency write with an unaligned address.
    do_req(1'b1, 32'h1004, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, 0, 0, 0, '0, 2'b00);
    idle(3);
    // Read with ar_ready held off for five cycles.
    do_req(1'b0, 32'h2000, '0, '0, 0, 0, 5, 0, 64'h1234_5678_9ABC_DEF0, 2'b00);
    idle(2);
    // W accepted three cycles ahead of AW, with the next request already waiting.
    do_req(1'b1, 32'h3008, 64'h0123_4567_89AB_CDEF, 8'h0F, 3, 0, 0, 1, '0, 2'b00);
    do_req(1'b0, 32'h3010, '0, '0, 0, 0, 0, 0, 64'h5555_AAAA_5555_AAAA, 2'b11);
    // DECERR read followed by an immediately granted write.
    do_req(1'b1, 32'h4000, 64'hFFFF_0000_FFFF_0000, 8'hA5, 0, 2, 0, 0, '0, 2'b10);
    idle(2);
    // Four mixed requests with mem_req_i held high throughout.
    do_req(1'b0, 32'h5001, '0, '0, 0, 0, 1, 1, 64'h1111_2222_3333_4444, 2'b01);
    do_req(1'b1, 32'h5008, 64'h0F0F_0F0F_F0F0_F0F0, 8'h3C, 1, 1, 0, 0, '0, 2'b00);
    do_req(1'b0, 32'h5010, '0, '0, 0, 0, 0, 2, 64'h9999_8888_7777_6666, 2'b00);
    do_req(1'b1, 32'h501F, 64'h0000_0000_0000_0001, 8'h01, 2, 0, 0, 1, '0, 2'b11);
    idle(0);
    drain();

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = $urandom;
      do_req(we, a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(0);
    drain();

    // Unsolicited B/R beats while idle must not be accepted.
    stray = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 stray = 1'b0;
    repeat (2) @(posedge clk_i);

    // Reset while waiting for a slow B response.
    do_req(1'b1, 32'h6000, 64'hCAFE_F00D_CAFE_F00D, 8'hFF, 0, 0, 0, 40, '0, 2'b00);
    idle(0);
    for (int i = 0; i < 20 && !(m_aw_done && m_w_done); i++) @(negedge clk_i);
    check("reach_wr_resp", {m_aw_done, m_w_done}, 2'b11);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (6) @(posedge clk_i);
    do_req(1'b0, 32'h7000, '0, '0, 0, 0, 0, 0, 64'hABCD_EF01_2345_6789, 2'b00);
    idle(0);
    drain();
    repeat (3) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem2axi_bridge.md
MEM2AXI_BRIDGE -- requirements
Module: mem2axi_bridge

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, AXI/mem address width in bits.
REQ-002 SHALL have parameter DataWidth, default 64, AXI/mem data width in bits, a power of 2 and >=8.
REQ-003 SHALL have parameter IdWidth, default 4, AXI ID width; parameter AxiId, default 0, constant ID on AW/AR.
REQ-004 clk_i  in  1  clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 mem_req_i / mem_gnt_o  in/out  1/1  memory-side request handshake.
REQ-007 mem_addr_i  in  AddrWidth  byte address; mem_we_i  in  1  1=write.
REQ-008 mem_wdata_i  in  DataWidth  write data; mem_strb_i  in  DataWidth/8  byte enables.
REQ-009 mem_rvalid_o  out  1  one-cycle response pulse; mem_rdata_o  out  DataWidth  read data; mem_err_o  out  1  response error.
REQ-010 busy_o  out  1  high whenever state != IDLE.
REQ-011 axi_aw_valid_o/axi_aw_ready_i, axi_aw_addr_o (AddrWidth), axi_aw_id_o (IdWidth), axi_aw_len_o (8), axi_aw_size_o (3), axi_aw_burst_o (2)  AXI4 AW, master side.
REQ-012 axi_w_valid_o/axi_w_ready_i, axi_w_data_o (DataWidth), axi_w_strb_o (DataWidth/8), axi_w_last_o (1)  AXI4 W.
REQ-013 axi_b_valid_i/axi_b_ready_o, axi_b_resp_i (2)  AXI4 B.
REQ-014 axi_ar_valid_o/axi_ar_ready_i, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o  AXI4 AR, widths as AW.
REQ-015 axi_r_valid_i/axi_r_ready_o, axi_r_data_i (DataWidth), axi_r_resp_i (2), axi_r_last_i (1)  AXI4 R.

Function
REQ-016 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; at most one transaction outstanding.
REQ-017 mem_gnt_o SHALL equal mem_req_i AND (state==IDLE), combinationally.
REQ-018 On req&&gnt: latch addr (low log2(DataWidth/8) bits forced 0), wdata, strb, we; go WR_REQ if we=1 else RD_REQ.
REQ-019 WR_REQ: aw_valid and w_valid asserted from the next cycle; each deasserts after its own handshake; both may complete in the same or different cycles, in either order; when both done go WR_RESP.
REQ-020 WR_RESP: b_ready=1; on b_valid go IDLE, response: rdata=0, err=b_resp[1].
REQ-021 RD_REQ: ar_valid=1 until ar_ready, then RD_RESP; RD_RESP: r_ready=1; on r_valid go IDLE, response: rdata=r_data, err=r_resp[1]; r_last not checked.
REQ-022 Valid outputs, once asserted, SHALL hold with stable payload until handshake.
REQ-023 Constant fields: len=0, size=log2(DataWidth/8), burst=2'b01 (INCR), w_last=1, id=AxiId.
REQ-024 b_ready/r_ready SHALL be 0 outside WR_RESP/RD_RESP; stray B/R beats are not consumed.
REQ-025 Transition to IDLE and new grant: gnt may be asserted in the cycle after the B/R handshake.
REQ-026 Minimum latency (all readies high, responder answers next cycle): grant at cycle 0, AW/W or AR handshake cycle 1, B/R cycle 2, mem_rvalid_o per REQ-031.

Reset
REQ-027 On rst_ni low: state IDLE, all AXI valid/ready outputs 0, mem_rvalid_o 0, mem_err_o 0, mem_rdata_o 0, busy_o 0, latched payload 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction immediately with no response; system-level reset of the AXI responder is required.

Configuration
REQ-029 Macro MEM2AXI_BRIDGE_RESP_CUT_EN SHALL select response timing.
REQ-030 Without macro: mem_rvalid_o/mem_rdata_o/mem_err_o combinational, asserted in the B/R handshake cycle.
REQ-031 With macro: those outputs registered, asserted exactly one cycle after the handshake, held 0/last value otherwise; busy_o stays high through that cycle and no grant is given in it.

Verification
REQ-032 Write addr 0x1004, data 0xDEAD_BEEF_0BAD_F00D, strb 0xFF, all readies 1, b_resp OKAY -> aw_addr=0x1000, size=3, len=0, one rvalid pulse, err=0.
REQ-033 Read, ar_ready delayed 5 cycles, r_data 0x1234_5678_9ABC_DEF0 -> ar_valid held 6 cycles with stable addr, rvalid with that data, err=0.
REQ-034 Write with w_ready high 3 cycles before aw_ready -> W handshake first, AW later, single B accepted, gnt low throughout.
REQ-035 Read with r_resp=DECERR (2'b11) -> rvalid with err=1; next request granted in following cycle.
REQ-036 Reset asserted in WR_RESP -> all outputs 0 asynchronously, state IDLE, no rvalid after release.
REQ-037 Back-to-back mem_req_i held high for 4 mixed read/write requests -> exactly 4 grants, 4 in-order responses, never two outstanding.
